// File: rtl/lab6_pkg.sv
// Shared types and helpers for the lab 6 pattern serializer.
// The PARITY state is only reached when PARITY_EN is defined.
package lab6_pkg;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SHIFT  = 2'd1,
      S_PARITY = 2'd2
   } ser_state_t;

   localparam int DEFAULT_WIDTH = 8;

   // Even parity over a zero-extended word; the padding bits do not affect the result.
   function automatic logic even_parity(input logic [31:0] data);
      return ^data;
   endfunction

endpackage

// File: rtl/pattern_serializer.sv
// MSB-first parallel-to-serial source feeding the pattern detector's `a` input.
// Define PARITY_EN to append an even-parity bit after the LSB of every word.
module pattern_serializer
   import lab6_pkg::*;
#(
   parameter int   WIDTH      = DEFAULT_WIDTH,
   parameter logic IDLE_LEVEL = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_valid,
   input  logic [WIDTH-1:0] load_data,
   output logic             load_ready,
   output logic             a,
   output logic             busy,
   output logic             last
);

   localparam int            CW       = $clog2(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   ser_state_t       state_reg;
   logic [WIDTH-1:0] shift_reg;
   logic [CW-1:0]    cnt_reg;
   logic             a_reg;
   logic             busy_reg;
   logic             accept;
`ifdef PARITY_EN
   logic             parity_reg;
`endif

`ifdef PARITY_EN
   assign last = (state_reg == S_PARITY);
`else
   assign last = (state_reg == S_SHIFT) && (cnt_reg == CNT_LAST);
`endif

   // Accepting on the final bit lets consecutive words stream with no idle gap.
   assign load_ready = (state_reg == S_IDLE) || last;
   assign accept     = load_valid && load_ready;
   assign a          = a_reg;
   assign busy       = busy_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg  <= S_IDLE;
         shift_reg  <= '0;
         cnt_reg    <= '0;
         a_reg      <= IDLE_LEVEL;
         busy_reg   <= 1'b0;
`ifdef PARITY_EN
         parity_reg <= 1'b0;
`endif
      end else if (accept) begin
         state_reg  <= S_SHIFT;
         shift_reg  <= load_data;
         cnt_reg    <= '0;
         a_reg      <= load_data[WIDTH-1];
         busy_reg   <= 1'b1;
`ifdef PARITY_EN
         parity_reg <= even_parity(32'(load_data));
`endif
      end else begin
         case (state_reg)
            S_SHIFT: begin
               if (cnt_reg == CNT_LAST) begin
`ifdef PARITY_EN
                  state_reg <= S_PARITY;
                  a_reg     <= parity_reg;
                  busy_reg  <= 1'b1;
`else
                  state_reg <= S_IDLE;
                  a_reg     <= IDLE_LEVEL;
                  busy_reg  <= 1'b0;
`endif
               end else begin
                  // Bit currently on `a` is shift_reg[WIDTH-1]; the next one sits just below it.
                  shift_reg <= shift_reg << 1;
                  a_reg     <= shift_reg[WIDTH-2];
                  cnt_reg   <= cnt_reg + 1'b1;
               end
            end
            default: begin
               state_reg <= S_IDLE;
               a_reg     <= IDLE_LEVEL;
               busy_reg  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pattern_serializer.sv
// Self-checking bench for pattern_serializer: table-driven words plus hand-written corner sequences.
// Expected serial bits are queued at each accepting edge and compared by a negedge monitor.
module tb_pattern_serializer;

`ifdef PARITY_EN
   localparam bit PAR = 1'b1;
`else
   localparam bit PAR = 1'b0;
`endif

   // Hand-derived stream for each word: 8 data bits MSB-first, then its even-parity bit.
   localparam logic [8:0] E_B1 = 9'b1011_0001_0;
   localparam logic [8:0] E_07 = 9'b0000_0111_1;
   localparam logic [8:0] E_FE = 9'b1111_1110_1;
   localparam logic [8:0] E_01 = 9'b0000_0001_1;
   localparam logic [8:0] E_80 = 9'b1000_0000_1;
   localparam logic [8:0] E_55 = 9'b0101_0101_0;
   localparam logic [8:0] E_A5 = 9'b1010_0101_0;
   localparam logic [8:0] E_3C = 9'b0011_1100_0;
   localparam logic [8:0] E_0F = 9'b0000_1111_0;
   localparam logic [8:0] E_F0 = 9'b1111_0000_0;
   localparam logic [8:0] E_81 = 9'b1000_0001_0;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       load_valid = 1'b0;
   logic [7:0] load_data = 8'h00;
   logic       load_ready, a, busy, last;

   typedef struct packed {
      logic bit_a;
      logic bit_last;
   } exp_t;

   typedef struct {
      logic [7:0] data;
      logic [8:0] exp_bits;
   } vec_t;

   exp_t exp_q[$];
   vec_t vecs[6];
   int   tests = 0;
   int   fails = 0;
   bit   mon_en = 1'b0;

   always #5 clk = ~clk;

   pattern_serializer #(.WIDTH(8), .IDLE_LEVEL(1'b0)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_valid (load_valid),
      .load_data  (load_data),
      .load_ready (load_ready),
      .a          (a),
      .busy       (busy),
      .last       (last)
   );

   task automatic check(input string name, input logic act, input logic req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("[TB] FAIL %s: got %b expected %b at %0t", name, act, req, $time);
      end
   endtask

   // Scoreboard: every busy cycle consumes one queued bit; idle cycles must show the idle level.
   always @(negedge clk) begin
      if (mon_en) begin
         if (busy) begin
            if (exp_q.size() == 0) begin
               check("unexpected_busy", busy, 1'b0);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               check("serial_bit", a, e.bit_a);
               check("last_flag", last, e.bit_last);
            end
         end else begin
            check("idle_level", a, 1'b0);
            check("idle_last", last, 1'b0);
            if (exp_q.size() != 0) check("stream_gap", busy, 1'b1);
         end
      end
   end

   task automatic load_word(input logic [7:0] d, input logic [8:0] e, input bit expect_last);
      int n;
      n = 0;
      load_valid = 1'b1;
      load_data  = d;
      @(negedge clk);
      while (!load_ready && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (!load_ready) begin
         check("accept_timeout", load_ready, 1'b1);
         load_valid = 1'b0;
         return;
      end
      if (expect_last) check("accept_on_last", last, 1'b1);
      @(posedge clk);
      for (int i = 0; i < 8; i++) exp_q.push_back('{e[8-i], (i == 7) && !PAR});
      if (PAR) exp_q.push_back('{e[0], 1'b1});
      $display("[TB] word 0x%02h accepted at %0t", d, $time);
      #1 load_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      @(negedge clk);
      while (busy && n < 40) begin
         @(negedge clk);
         n++;
      end
      check("idle_timeout", busy, 1'b0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      vecs[0] = '{8'hB1, E_B1};
      vecs[1] = '{8'h07, E_07};
      vecs[2] = '{8'hFE, E_FE};
      vecs[3] = '{8'h01, E_01};
      vecs[4] = '{8'h80, E_80};
      vecs[5] = '{8'h55, E_55};

      // Reset held for two cycles
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_a", a, 1'b0);
      check("rst_load_ready", load_ready, 1'b1);
      check("rst_busy", busy, 1'b0);
      check("rst_last", last, 1'b0);
      @(posedge clk);
      #3 rst_n = 1'b1;
      mon_en = 1'b1;
      @(posedge clk);
      #1;

      // Table of single words, each followed by a return to idle
      foreach (vecs[i]) begin
         load_word(vecs[i].data, vecs[i].exp_bits, 1'b0);
         wait_idle();
         check("post_word_idle", a, 1'b0);
      end

      // Back-to-back: second word accepted on the first word's final bit
      load_word(8'hA5, E_A5, 1'b0);
      load_word(8'h3C, E_3C, 1'b1);
      wait_idle();

      // A load pulse mid-word must be ignored
      load_word(8'h0F, E_0F, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      load_valid = 1'b1;
      load_data  = 8'hFF;
      @(negedge clk);
      check("busy_not_ready", load_ready, 1'b0);
      @(posedge clk);
      #1 load_valid = 1'b0;
      wait_idle();

      // Abort at bit 4 with an asynchronous reset, then a fresh word
      load_word(8'hF0, E_F0, 1'b0);
      repeat (4) @(posedge clk);
      #2;
      exp_q.delete();
      rst_n = 1'b0;
      #1;
      check("abort_a", a, 1'b0);
      check("abort_busy", busy, 1'b0);
      check("abort_load_ready", load_ready, 1'b1);
      check("abort_last", last, 1'b0);
      @(posedge clk);
      #3 rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      load_word(8'h81, E_81, 1'b0);
      wait_idle();

      check("queue_drained", exp_q.size() == 0, 1'b1);
      mon_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
